// File: rtl/sd_dat_pkg.sv
// sd_dat_pkg: shared types and constants for the SD DAT receive path
package sd_dat_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE} state_t;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int DAT_W = 4;
  localparam logic [3:0] START_NIBBLE = 4'h0;
  localparam logic [3:0] END_NIBBLE = 4'hF;
endpackage

// File: rtl/sd_crc16_serial.sv
// sd_crc16_serial: bit-serial CRC16-CCITT (init 0) for one DAT line
module sd_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  // shift in one bit per enabled cycle, feedback taps from the polynomial
  always_ff @(posedge sd_clock)
    if (reset || clr) crc <= '0;
    else if (en) crc <= {crc[14:0], 1'b0} ^ ((bit_in ^ crc[15]) ? CRC16_POLY : 16'h0);
endmodule

// File: rtl/sd_dat_rx_framer.sv
// sd_dat_rx_framer: frames one SD data block from the DAT lines, checks CRC16 and end bit
module sd_dat_rx_framer
  import sd_dat_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             sd_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DAT_W-1:0] dat_in,
  output logic [DAT_W-1:0] nibble_out,
  output logic             nibble_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_err,
  output logic             end_err,
  output logic             timeout
);
  localparam int NW = $clog2(2 * BLOCK_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [NW-1:0] LAST_NIB = NW'(2 * BLOCK_BYTES - 1);
  localparam logic [TW-1:0] LAST_TO = TW'(TIMEOUT_CYC - 1);
  state_t r_state;
  logic [NW-1:0] r_nib_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [3:0] r_bit_cnt;
  logic [15:0] w_crc [DAT_W];
  logic [DAT_W-1:0] w_exp;
  for (genvar i = 0; i < DAT_W; i++) begin : g_crc
    sd_crc16_serial u_crc (
      .sd_clock(sd_clock),
      .reset(reset),
      .clr(r_state == S_IDLE),
      .en(r_state == S_DATA),
      .bit_in(dat_in[i]),
      .crc(w_crc[i])
    );
  end
  // expected CRC bit per line for the current CRC cycle, MSB first
  always_comb begin
    w_exp = '0;
    for (int j = 0; j < DAT_W; j++) w_exp[j] = w_crc[j][~r_bit_cnt];
  end
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  // block framing FSM with registered data path and sticky status
  always_ff @(posedge sd_clock)
    if (reset) begin
      r_state <= S_IDLE;
      r_nib_cnt <= '0;
      r_to_cnt <= '0;
      r_bit_cnt <= '0;
      nibble_out <= '0;
      nibble_valid <= 1'b0;
      crc_err <= 1'b0;
      end_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      nibble_valid <= r_state == S_DATA;
      nibble_out <= (r_state == S_DATA) ? dat_in : nibble_out;
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (start) begin
            r_state <= S_WAIT_START;
            crc_err <= 1'b0;
            end_err <= 1'b0;
            timeout <= 1'b0;
          end
        end
        S_WAIT_START:
          if (dat_in == START_NIBBLE) begin
            r_state <= S_DATA;
            r_nib_cnt <= '0;
          end else if (r_to_cnt == LAST_TO) begin
            timeout <= 1'b1;
            r_state <= S_IDLE;
          end else r_to_cnt <= r_to_cnt + 1'b1;
        S_DATA: begin
          r_nib_cnt <= r_nib_cnt + 1'b1;
          if (r_nib_cnt == LAST_NIB) begin
            r_state <= S_CRC;
            r_bit_cnt <= '0;
          end
        end
        S_CRC: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (dat_in != w_exp) crc_err <= 1'b1;
          if (r_bit_cnt == 4'hF) r_state <= S_END;
        end
        S_END: begin
          if (dat_in != END_NIBBLE) end_err <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sd_dat_rx_framer.sv
// tb_sd_dat_rx_framer: randomized block receive against a queue/polynomial-division reference
module tb_sd_dat_rx_framer;
  localparam int BB = 4;
  localparam int TO = 16;
  localparam int NN = 2 * BB;
  logic sd_clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [3:0] dat_in = 4'hF;
  logic [3:0] nibble_out;
  logic nibble_valid, busy, done, crc_err, end_err, timeout;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [3:0] exp_q[$];
  logic exp_crc = 1'b0;
  logic exp_end = 1'b0;
  logic [31:0] deser = '0;

  sd_dat_rx_framer #(.BLOCK_BYTES(BB), .TIMEOUT_CYC(TO)) dut (
    .sd_clock(sd_clock),
    .reset(reset),
    .start(start),
    .dat_in(dat_in),
    .nibble_out(nibble_out),
    .nibble_valid(nibble_valid),
    .busy(busy),
    .done(done),
    .crc_err(crc_err),
    .end_err(end_err),
    .timeout(timeout)
  );

  always #5 sd_clock = ~sd_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, message MSB first
  function automatic logic [15:0] crc_of(input logic [0:255] m, input int n);
    logic [0:271] a;
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    a = {m, 16'h0};
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j < 17; j++) a[i+j] = a[i+j] ^ g[16-j];
    for (int j = 0; j < 16; j++) r[15-j] = a[n+j];
    return r;
  endfunction

  // every meaningful output cycle: nibbles in order, flags at done
  always @(negedge sd_clock) begin
    if (nibble_valid) begin
      chk("valid_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("nibble", nibble_out, exp_q.pop_front());
      deser = {deser[27:0], nibble_out};
    end
    if (done) begin
      done_cnt++;
      chk("done_flags", {crc_err, end_err, timeout}, {exp_crc, exp_end, 1'b0});
      chk("done_pending", exp_q.size(), 0);
    end
  end

  task automatic cyc(input logic [3:0] d, input logic s = 1'b0);
    start = s;
    dat_in = d;
    @(posedge sd_clock);
    #1;
    start = 1'b0;
  endtask

  task automatic recv(input logic [3:0] nib[NN], input int fl, input int fb,
                      input logic [3:0] endv, input bit spam, input bit zs);
    logic [0:255] m;
    logic [15:0] c[4];
    logic [31:0] w;
    logic [3:0] v;
    int ic, sd, sc, d0;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      m = '0;
      for (int k = 0; k < NN; k++) m[k] = nib[k][l];
      c[l] = crc_of(m, NN);
    end
    for (int k = 0; k < NN; k++) w = {w[27:0], nib[k]};
    exp_crc = fl >= 0;
    exp_end = endv != 4'hF;
    ic = $urandom_range(0, 6);
    sd = spam ? int'($urandom_range(0, NN - 1)) : -1;
    sc = spam ? int'($urandom_range(0, 15)) : -1;
    d0 = done_cnt;
    cyc(zs ? 4'h0 : 4'hF, 1'b1);
    chk("busy_armed", busy, 1);
    repeat (ic) cyc(4'($urandom_range(1, 15)));
    cyc(4'h0);
    for (int k = 0; k < NN; k++) begin
      exp_q.push_back(nib[k]);
      cyc(nib[k], k == sd);
    end
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 4; l++) v[l] = c[l][15-k] ^ ((l == fl) && (15 - k == fb));
      cyc(v, k == sc);
    end
    cyc(endv);
    chk("done_busy", {done, busy}, 2'b11);
    cyc(4'hF);
    chk("done_count", done_cnt - d0, 1);
    chk("back_idle", {done, busy, nibble_valid}, 0);
    chk("flags_hold", {crc_err, end_err, timeout}, {exp_crc, exp_end, 1'b0});
    chk("deser_word", deser, w);
  endtask

  initial begin
    logic [3:0] d1[NN];
    logic [3:0] rn[NN];
    logic [0:255] m;
    logic [71:0] s9;
    int d0, fl;
    d1 = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};
    s9 = "123456789";
    m = '0;
    m[0:71] = s9;
    chk("model_crc_check_string", crc_of(m, 72), 16'h31C3);
    m = '0;
    m[0] = 1'b1;
    chk("model_crc_single_one", crc_of(m, 1), 16'h1021);
    repeat (3) cyc(4'hF, 1'b1);
    chk("reset_outputs", {nibble_out, nibble_valid, busy, done, crc_err, end_err, timeout}, 0);
    reset = 1'b0;
    cyc(4'hF);
    chk("post_reset_idle", {nibble_out, nibble_valid, busy, done, crc_err, end_err, timeout}, 0);
    // nominal, CRC error, end-bit error
    recv(d1, -1, 0, 4'hF, 1'b0, 1'b0);
    chk("nominal_word", deser, 32'hDEADBEEF);
    recv(d1, 2, 7, 4'hF, 1'b0, 1'b0);
    chk("crc_err_literal", {crc_err, end_err}, 2'b10);
    recv(d1, -1, 0, 4'b1011, 1'b0, 1'b0);
    chk("end_err_literal", {crc_err, end_err}, 2'b01);
    // start-bit timeout with a partial start inserted
    d0 = done_cnt;
    cyc(4'hF, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      cyc(k == 5 ? 4'b0111 : 4'hF);
      chk("timeout_flag", {timeout, busy}, k < TO ? 2'b01 : 2'b10);
    end
    cyc(4'hF);
    chk("timeout_hold", {timeout, busy, done}, 3'b100);
    chk("timeout_no_done", done_cnt - d0, 0);
    // reset in the middle of a block
    d0 = done_cnt;
    cyc(4'hF, 1'b1);
    cyc(4'h0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(d1[k]);
      cyc(d1[k]);
    end
    reset = 1'b1;
    cyc(d1[3]);
    chk("abort_outputs", {nibble_out, nibble_valid, busy, done, crc_err, end_err, timeout}, 0);
    reset = 1'b0;
    cyc(4'hF);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_queue", exp_q.size(), 0);
    recv(d1, -1, 0, 4'hF, 1'b0, 1'b0);
    chk("after_abort_word", deser, 32'hDEADBEEF);
    // start while busy, and start together with a start bit
    recv(d1, -1, 0, 4'hF, 1'b1, 1'b1);
    // randomized blocks
    repeat (24) begin
      for (int k = 0; k < NN; k++) rn[k] = 4'($urandom);
      fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      recv(rn, fl, int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF,
           1'($urandom), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
